// File: rtl/pad_scan_ctrl.sv
// Round-robin pad channel scanner: settle, measure hits/link health over a dwell window, report per channel.
// Optional break counter built only when PAD_SCAN_BREAK_CNT_EN is defined; otherwise rpt_breaks is tied to 0.
module pad_scan_ctrl #(
    parameter int CH_W    = 2,
    parameter int DWELL_W = 16,
    parameter int SETTLE  = 4
) (
    input  logic                 clk160,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [DWELL_W-1:0]   dwell,
    input  logic [2**CH_W-1:0]   ch_data_valid,
    input  logic [2**CH_W-1:0]   ch_linked,
    output logic [CH_W-1:0]      ch_sel,
    output logic                 busy,
    output logic                 rpt_valid,
    input  logic                 rpt_ready,
    output logic [CH_W-1:0]      rpt_ch,
    output logic [DWELL_W-1:0]   rpt_hits,
    output logic                 rpt_unlocked,
    output logic [7:0]           rpt_breaks
);

    localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEASURE, S_REPORT} state_t;

    state_t               state_q, state_d;
    logic [CH_W-1:0]      ch_sel_q, ch_sel_d;
    logic [SC_W-1:0]      settle_cnt_q, settle_cnt_d;
    logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
    logic [DWELL_W-1:0]   hits_q, hits_d, hits_nxt;
    logic                 unl_q, unl_d, unl_nxt;
    logic [CH_W-1:0]      rpt_ch_q, rpt_ch_d;
    logic [DWELL_W-1:0]   rpt_hits_q, rpt_hits_d;
    logic                 rpt_unl_q, rpt_unl_d;
    logic                 cur_lnk, cur_hit;
`ifdef PAD_SCAN_BREAK_CNT_EN
    logic                 prev_lnk_q, prev_lnk_d;
    logic [7:0]           brk_q, brk_d, brk_nxt;
    logic [7:0]           rpt_brk_q, rpt_brk_d;
`endif

    assign cur_lnk  = ch_linked[ch_sel_q];
    assign cur_hit  = ch_data_valid[ch_sel_q];
    assign hits_nxt = (cur_hit && (hits_q != '1)) ? hits_q + DWELL_W'(1) : hits_q;
    assign unl_nxt  = unl_q | ~cur_lnk;
`ifdef PAD_SCAN_BREAK_CNT_EN
    // A link already low at window open was captured in prev_lnk, so it cannot count as a break.
    assign brk_nxt  = (prev_lnk_q && !cur_lnk && (brk_q != 8'hFF)) ? brk_q + 8'd1 : brk_q;
`endif

    always_comb begin
        state_d      = state_q;
        ch_sel_d     = ch_sel_q;
        settle_cnt_d = settle_cnt_q;
        dwell_cnt_d  = dwell_cnt_q;
        hits_d       = hits_q;
        unl_d        = unl_q;
        rpt_ch_d     = rpt_ch_q;
        rpt_hits_d   = rpt_hits_q;
        rpt_unl_d    = rpt_unl_q;
`ifdef PAD_SCAN_BREAK_CNT_EN
        prev_lnk_d   = prev_lnk_q;
        brk_d        = brk_q;
        rpt_brk_d    = rpt_brk_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d      = S_SETTLE;
                    settle_cnt_d = SC_W'(SETTLE - 1);
                end
            end
            S_SETTLE: begin
                if (settle_cnt_q == '0) begin
                    state_d     = S_MEASURE;
                    dwell_cnt_d = (dwell == '0) ? DWELL_W'(1) : dwell;
                    hits_d      = '0;
                    unl_d       = 1'b0;
`ifdef PAD_SCAN_BREAK_CNT_EN
                    prev_lnk_d  = cur_lnk;
                    brk_d       = '0;
`endif
                end else begin
                    settle_cnt_d = settle_cnt_q - SC_W'(1);
                end
            end
            S_MEASURE: begin
                hits_d      = hits_nxt;
                unl_d       = unl_nxt;
                dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
`ifdef PAD_SCAN_BREAK_CNT_EN
                prev_lnk_d  = cur_lnk;
                brk_d       = brk_nxt;
`endif
                // Record includes this final window cycle's sample.
                if (dwell_cnt_q == DWELL_W'(1)) begin
                    state_d    = S_REPORT;
                    rpt_ch_d   = ch_sel_q;
                    rpt_hits_d = hits_nxt;
                    rpt_unl_d  = unl_nxt;
`ifdef PAD_SCAN_BREAK_CNT_EN
                    rpt_brk_d  = brk_nxt;
`endif
                end
            end
            S_REPORT: begin
                if (rpt_ready) begin
                    ch_sel_d = ch_sel_q + CH_W'(1);
                    if (enable) begin
                        state_d      = S_SETTLE;
                        settle_cnt_d = SC_W'(SETTLE - 1);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk160 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            ch_sel_q     <= '0;
            settle_cnt_q <= '0;
            dwell_cnt_q  <= '0;
            hits_q       <= '0;
            unl_q        <= 1'b0;
            rpt_ch_q     <= '0;
            rpt_hits_q   <= '0;
            rpt_unl_q    <= 1'b0;
`ifdef PAD_SCAN_BREAK_CNT_EN
            prev_lnk_q   <= 1'b0;
            brk_q        <= '0;
            rpt_brk_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ch_sel_q     <= ch_sel_d;
            settle_cnt_q <= settle_cnt_d;
            dwell_cnt_q  <= dwell_cnt_d;
            hits_q       <= hits_d;
            unl_q        <= unl_d;
            rpt_ch_q     <= rpt_ch_d;
            rpt_hits_q   <= rpt_hits_d;
            rpt_unl_q    <= rpt_unl_d;
`ifdef PAD_SCAN_BREAK_CNT_EN
            prev_lnk_q   <= prev_lnk_d;
            brk_q        <= brk_d;
            rpt_brk_q    <= rpt_brk_d;
`endif
        end
    end

    assign ch_sel       = ch_sel_q;
    assign busy         = (state_q != S_IDLE);
    assign rpt_valid    = (state_q == S_REPORT);
    assign rpt_ch       = rpt_ch_q;
    assign rpt_hits     = rpt_hits_q;
    assign rpt_unlocked = rpt_unl_q;
`ifdef PAD_SCAN_BREAK_CNT_EN
    assign rpt_breaks   = rpt_brk_q;
`else
    assign rpt_breaks   = 8'd0;
`endif

endmodule

// File: tb/tb_pad_scan_ctrl.sv
// Directed bench for pad_scan_ctrl: timestamp-based scan model checked every cycle, plus literal spot checks.
module tb_pad_scan_ctrl;

    localparam int CH_W    = 2;
    localparam int DWELL_W = 16;
    localparam int SETTLE  = 4;

    logic                clk160 = 1'b0;
    logic                reset_n;
    logic                enable;
    logic [DWELL_W-1:0]  dwell;
    logic [3:0]          ch_data_valid;
    logic [3:0]          ch_linked;
    logic [CH_W-1:0]     ch_sel;
    logic                busy;
    logic                rpt_valid;
    logic                rpt_ready;
    logic [CH_W-1:0]     rpt_ch;
    logic [DWELL_W-1:0]  rpt_hits;
    logic                rpt_unlocked;
    logic [7:0]          rpt_breaks;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    pad_scan_ctrl #(.CH_W(CH_W), .DWELL_W(DWELL_W), .SETTLE(SETTLE)) dut (
        .clk160        (clk160),
        .reset_n       (reset_n),
        .enable        (enable),
        .dwell         (dwell),
        .ch_data_valid (ch_data_valid),
        .ch_linked     (ch_linked),
        .ch_sel        (ch_sel),
        .busy          (busy),
        .rpt_valid     (rpt_valid),
        .rpt_ready     (rpt_ready),
        .rpt_ch        (rpt_ch),
        .rpt_hits      (rpt_hits),
        .rpt_unlocked  (rpt_unlocked),
        .rpt_breaks    (rpt_breaks)
    );

    always #5 clk160 = ~clk160;
    always @(posedge clk160) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a channel visit starts at edge k0; the window samples edges k0+SETTLE+1 .. k0+SETTLE+dw
    // and the record is presented after edge k0+SETTLE+dw.
    bit              m_busy, m_valid, prv, lk;
    logic [CH_W-1:0] m_sel, m_ch;
    logic [15:0]     m_hits;
    logic            m_unl;
    logic [7:0]      m_brk;
    int              k0, dw, hits, brk;
    bit              unl;

    always @(posedge clk160 or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 0; m_valid = 0; m_sel = '0; m_ch = '0;
            m_hits = '0; m_unl = 1'b0; m_brk = '0;
            k0 = 0; dw = 1; hits = 0; brk = 0; unl = 0; prv = 0;
        end else if (!m_busy) begin
            if (enable) begin
                m_busy = 1;
                k0 = cyc;
            end
        end else if (!m_valid) begin
            if (cyc == k0 + SETTLE) begin
                dw   = (dwell == 0) ? 1 : int'(dwell);
                prv  = ch_linked[m_sel];
                hits = 0; brk = 0; unl = 0;
            end else if (cyc > k0 + SETTLE) begin
                lk = ch_linked[m_sel];
                if (ch_data_valid[m_sel] && hits < 65535) hits++;
                if (!lk) unl = 1;
                if (prv && !lk && brk < 255) brk++;
                prv = lk;
                if (cyc == k0 + SETTLE + dw) begin
                    m_valid = 1;
                    m_ch    = m_sel;
                    m_hits  = 16'(hits);
                    m_unl   = unl;
`ifdef PAD_SCAN_BREAK_CNT_EN
                    m_brk   = 8'(brk);
`else
                    m_brk   = 8'd0;
`endif
                end
            end
        end else if (rpt_ready) begin
            m_valid = 0;
            m_sel   = m_sel + 1'b1;
            if (enable) k0 = cyc;
            else m_busy = 0;
        end
    end

    always @(negedge clk160) begin
        chk("busy",         32'(busy),         32'(m_busy));
        chk("ch_sel",       32'(ch_sel),       32'(m_sel));
        chk("rpt_valid",    32'(rpt_valid),    32'(m_valid));
        chk("rpt_ch",       32'(rpt_ch),       32'(m_ch));
        chk("rpt_hits",     32'(rpt_hits),     32'(m_hits));
        chk("rpt_unlocked", 32'(rpt_unlocked), 32'(m_unl));
        chk("rpt_breaks",   32'(rpt_breaks),   32'(m_brk));
    end

    task automatic wait_valid(input int budget, output int t);
        int n;
        n = 0;
        t = -1;
        while (n < budget) begin
            @(negedge clk160);
            n++;
            if (rpt_valid) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_valid: no rpt_valid within %0d cycles, expected one", budget);
        end
    endtask

    int t_busy, t_v, t_prev, n;
    logic [7:0] exp_brk;

    initial begin
        reset_n = 1'b0; enable = 1'b0; dwell = 16'd10; rpt_ready = 1'b1;
        ch_data_valid = 4'b0001; ch_linked = 4'b1111;
        #2;
        chk("reset ch_sel", 32'(ch_sel), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset rpt_valid", 32'(rpt_valid), 0);
        chk("reset rpt_hits", 32'(rpt_hits), 0);
        repeat (2) @(negedge clk160);
        reset_n = 1'b1;
        @(negedge clk160);
        enable = 1'b1;

        // First report lands on the 15th cycle counting busy's first cycle as 1.
        t_busy = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk160);
            if (busy) begin t_busy = cyc; break; end
        end
        chk("busy rose", 32'(t_busy >= 0), 1);
        wait_valid(100, t_v);
        chk("first valid offset", 32'(t_v - t_busy), 14);
        chk("first rpt_ch", 32'(rpt_ch), 0);
        chk("first rpt_hits", 32'(rpt_hits), 10);
        chk("first rpt_unlocked", 32'(rpt_unlocked), 0);
        t_prev = t_v;
        for (int i = 1; i < 5; i++) begin
            wait_valid(100, t_v);
            chk("scan rpt_ch", 32'(rpt_ch), 32'(i % 4));
            chk("scan period", 32'(t_v - t_prev), 15);
            chk("scan rpt_hits", 32'(rpt_hits), (i % 4 == 0) ? 10 : 0);
            t_prev = t_v;
        end

        // Transfer of ch0 happens at the next edge; ch1 then settles and measures with two link drops.
        @(posedge clk160); #1;
        rpt_ready = 1'b0;
        ch_data_valid = 4'b0011;
        repeat (5) @(posedge clk160); #1; ch_linked[1] = 1'b0;
        repeat (2) @(posedge clk160); #1; ch_linked[1] = 1'b1;
        repeat (2) @(posedge clk160); #1; ch_linked[1] = 1'b0;
        repeat (1) @(posedge clk160); #1; ch_linked[1] = 1'b1;
        wait_valid(100, t_v);
`ifdef PAD_SCAN_BREAK_CNT_EN
        exp_brk = 8'd2;
`else
        exp_brk = 8'd0;
`endif
        dwell = 16'd0;
        ch_data_valid = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            chk("hold rpt_valid", 32'(rpt_valid), 1);
            chk("hold rpt_ch", 32'(rpt_ch), 1);
            chk("hold rpt_hits", 32'(rpt_hits), 10);
            chk("hold rpt_unlocked", 32'(rpt_unlocked), 1);
            chk("hold rpt_breaks", 32'(rpt_breaks), 32'(exp_brk));
            chk("hold ch_sel", 32'(ch_sel), 1);
            @(negedge clk160);
        end
        rpt_ready = 1'b1;

        // dwell=0 gives one-cycle windows: period SETTLE+1+1.
        wait_valid(100, t_prev);
        chk("dwell0 rpt_ch", 32'(rpt_ch), 2);
        chk("dwell0 rpt_hits", 32'(rpt_hits), 1);
        wait_valid(100, t_v);
        chk("dwell0 rpt_ch next", 32'(rpt_ch), 3);
        chk("dwell0 period", 32'(t_v - t_prev), 6);
        dwell = 16'hFFFF;
        wait_valid(70000, t_v);
        chk("max dwell rpt_ch", 32'(rpt_ch), 0);
        chk("max dwell rpt_hits", 32'(rpt_hits), 32'h0000FFFF);
        dwell = 16'd10;

        // Drop enable mid-window on ch1: report completes, then idle.
        repeat (SETTLE + 6) @(posedge clk160); #1;
        enable = 1'b0;
        wait_valid(100, t_v);
        chk("drain rpt_ch", 32'(rpt_ch), 1);
        chk("drain rpt_hits", 32'(rpt_hits), 10);
        @(negedge clk160);
        chk("drain busy", 32'(busy), 0);
        chk("drain rpt_valid", 32'(rpt_valid), 0);
        chk("drain ch_sel", 32'(ch_sel), 2);
        repeat (5) @(negedge clk160);
        chk("idle busy", 32'(busy), 0);

        // Reset mid-window on ch2 clears everything immediately.
        enable = 1'b1;
        repeat (SETTLE + 5) @(posedge clk160); #1;
        chk("pre-reset busy", 32'(busy), 1);
        reset_n = 1'b0;
        #1;
        chk("rst ch_sel", 32'(ch_sel), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst rpt_valid", 32'(rpt_valid), 0);
        chk("rst rpt_ch", 32'(rpt_ch), 0);
        chk("rst rpt_hits", 32'(rpt_hits), 0);
        chk("rst rpt_unlocked", 32'(rpt_unlocked), 0);
        chk("rst rpt_breaks", 32'(rpt_breaks), 0);
        @(negedge clk160);
        enable = 1'b0;
        reset_n = 1'b1;
        n = 0;
        repeat (5) @(negedge clk160);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pad_scan_ctrl.md
# pad_scan_ctrl

Round-robin scheduler that time-shares one pad-data checker and readout path among `2**CH_W` pad channels. It drives the external channel-select mux and lets the selected link settle. It then measures hit frames and link health over a programmable dwell window and hands one result record per channel to readout over a valid/ready handshake. It sits between the per-channel pad data checkers and the slow-control/monitoring readout, in the `clk160` domain.

## Interface
- `CH_W`, 2, channel index width; channel count is `NUM_CH = 2**CH_W`.
- `DWELL_W`, 16, width of the dwell setting and of the hit counter.
- `SETTLE`, 4, idle cycles after each `ch_sel` change before measuring; minimum 1.

- `clk160` in 1: sole clock; all logic is on its rising edge.
- `reset_n` in 1: asynchronous reset, active-low.
- `enable` in 1: run the scan while high.
- `dwell` in DWELL_W: measurement window length in cycles; a value of 0 is treated as 1.
- `ch_data_valid` in NUM_CH: per-channel hit-frame strobe (hit flag AND pad data valid).
- `ch_linked` in NUM_CH: per-channel link-locked status.
- `ch_sel` out CH_W: channel routed to the shared checker.
- `busy` out 1: high in any state other than IDLE.
- `rpt_valid` out 1: result record is valid.
- `rpt_ready` in 1: readout accepts the record.
- `rpt_ch` out CH_W: channel index of the record.
- `rpt_hits` out DWELL_W: count of `ch_data_valid[ch_sel]` cycles in the window; saturates at all-ones.
- `rpt_unlocked` out 1: `ch_linked[ch_sel]` was low on at least one window cycle.
- `rpt_breaks` out 8: count of falling edges of `ch_linked[ch_sel]` in the window; saturates at 255.

## Operation
- FSM states: IDLE, SETTLE, MEASURE, REPORT.
- IDLE → SETTLE when `enable`=1. Channel 0 is used after reset; otherwise the current `ch_sel` is used.
- SETTLE:
  - Lasts exactly SETTLE cycles. Inputs are ignored.
  - On the last cycle, clear the counters, latch `dwell` (0→1), and load the previous-linked register from `ch_linked[ch_sel]`.
  - Then go to MEASURE.
- MEASURE:
  - Lasts exactly the latched dwell count of cycles. A `dwell` change mid-window is ignored.
  - Each cycle: increment the hit counter if `ch_data_valid[ch_sel]` (saturating); set the unlocked flag if `ch_linked[ch_sel]`=0; increment breaks if the previous-linked value is 1 and the current value is 0.
  - Then go to REPORT.
- REPORT:
  - Register the record fields and hold `rpt_valid`=1 with all fields stable until `rpt_valid && rpt_ready`.
  - On the transfer cycle, advance `ch_sel` (NUM_CH-1 wraps to 0).
  - Next state: SETTLE if `enable`=1, else IDLE.
- Deasserting `enable` in SETTLE, MEASURE or REPORT does not abort. The current channel completes through its report, then the FSM goes to IDLE.
- A link that is already low when the window opens produces no break count, but sets `rpt_unlocked`.

## Timing
- Reset values: `ch_sel`=0, `busy`=0, `rpt_valid`=0, `rpt_ch`=0, `rpt_hits`=0, `rpt_unlocked`=0, `rpt_breaks`=0, FSM in IDLE. Asserting reset mid-operation returns to these values immediately, and any pending record is discarded.
- `busy` rises the cycle after `enable` is sampled high in IDLE.
- `rpt_valid` rises the cycle after the last MEASURE cycle.
- Channel period with `rpt_ready` held at 1 = SETTLE + dwell + 1 cycles.
- `rpt_valid` falls the cycle after the transfer; `ch_sel` changes on that same edge.
- `rpt_ready` may be asserted before `rpt_valid`. While `rpt_ready` is low, no new window starts.

## Configuration
- `PAD_SCAN_BREAK_CNT_EN` defined: the break counter and previous-linked register are built, and `rpt_breaks` behaves as specified.
- Not defined: that logic is removed, `rpt_breaks` is tied to 0, and all other behaviour is unchanged.

## Test plan
- Reset, `enable`=1, SETTLE=4, `dwell`=10, `rpt_ready`=1, channel 0 strobing every cycle → first `rpt_valid` at cycle 15 after `busy` rises, with `rpt_ch`=0, `rpt_hits`=10, `rpt_unlocked`=0.
- Full scan with `rpt_ready`=1 → `rpt_ch` sequence 0,1,2,3,0; consecutive `rpt_valid` pulses are 15 cycles apart.
- Hold `rpt_ready`=0 for 20 cycles during REPORT → `rpt_valid` and all fields stay constant, `ch_sel` stays unchanged, and no MEASURE occurs.
- Drop `ch_linked[1]` twice during channel 1's window (macro defined) → `rpt_breaks`=2, `rpt_unlocked`=1. Same run with the macro undefined → `rpt_breaks`=0, `rpt_unlocked`=1.
- `dwell`=0 → window of exactly 1 cycle; `dwell`=16'hFFFF with a constant strobe → `rpt_hits`=16'hFFFF, no wrap.
- Drop `enable` mid-MEASURE → the report still completes, then the FSM enters IDLE and `busy`=0. Pulse `reset_n` low mid-MEASURE → all outputs return to 0 immediately.
